cassette_fsk_tx: RTL and testbench



---
 rtl/cassette_fsk_tx.sv | 127 ++++++++++++
 tb/tb_cassette_fsk_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cassette_fsk_tx.sv
// cassette_fsk_tx: MC-10 cassette playback transmitter.
// Turns bytes taken over a valid/ready handshake into FSK tape audio.
// Bits go out LSB first. A 0 bit is one cycle at HALF0 (1200 Hz) and
// a 1 bit is one cycle at HALF1 (2400 Hz). Each cycle is a HIGH
// half-period followed by a LOW half-period.
//
// Handshake: a byte transfers on any rising edge where in_valid and in_ready
// are both 1. in_ready never depends on in_valid. Once in_valid is raised,
// the source holds it and in_data steady until the transfer happens.
// motor_on=0 freezes playback in place and forces tape_out low.
module cassette_fsk_tx #(
    parameter int HALF0 = 1491,
    parameter int HALF1 = 746
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       motor_on,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tape_out,
    output logic       busy
);

    localparam logic [15:0] H0 = 16'(HALF0);
    localparam logic [15:0] H1 = 16'(HALF1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] half, half_n;
    logic        tape_n;
    logic        phase_end;
    logic        byte_end;
    logic        accept;

    // The current half-period ends when the counter reaches half-1.
    // The byte ends at that point in the LOW phase of bit 7.
    assign phase_end = (cnt == (half - 16'd1));
    assign byte_end  = (state == LOW) && (bit_idx == 3'd7) && phase_end;

    // State register and datapath registers. tape_out is registered so that
    // no input reaches it through combinational logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= 8'd0;
            bit_idx  <= 3'd0;
            cnt      <= 16'd0;
            half     <= H0;
            tape_out <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_idx  <= bit_idx_n;
            cnt      <= cnt_n;
            half     <= half_n;
            tape_out <= tape_n;
        end
    end

    // Next-state logic. With the motor off, every register holds its value.
    // When the last bit ends, a pending byte is loaded at once, so no gap
    // cycle appears between bytes.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        cnt_n     = cnt;
        half_n    = half;
        if (motor_on) begin
            if (accept) begin
                shreg_n   = in_data;
                bit_idx_n = 3'd0;
                cnt_n     = 16'd0;
                half_n    = in_data[0] ? H1 : H0;
                state_n   = HIGH;
            end else begin
                case (state)
                    HIGH: begin
                        if (phase_end) begin
                            cnt_n   = 16'd0;
                            state_n = LOW;
                        end else begin
                            cnt_n = cnt + 16'd1;
                        end
                    end
                    LOW: begin
                        if (phase_end) begin
                            cnt_n = 16'd0;
                            if (bit_idx == 3'd7) begin
                                state_n = IDLE;
                            end else begin
                                shreg_n   = {1'b0, shreg[7:1]};
                                bit_idx_n = bit_idx + 3'd1;
                                half_n    = shreg[1] ? H1 : H0;
                                state_n   = HIGH;
                            end
                        end else begin
                            cnt_n = cnt + 16'd1;
                        end
                    end
                    default: begin
                        state_n = state;
                    end
                endcase
            end
        end
    end

    // Output logic. in_ready is asserted when idle, or on the last LOW
    // cycle of a byte. tape_n is the level tape_out takes on the next edge.
    always_comb begin
        in_ready = motor_on && !reset && ((state == IDLE) || byte_end);
        accept   = in_valid && in_ready;
        busy     = (state != IDLE);
        tape_n   = motor_on && (state_n == HIGH);
    end

endmodule

// File: tb/tb_cassette_fsk_tx.sv
// tb_cassette_fsk_tx: bench for cassette_fsk_tx (HALF0=4, HALF1=2).
// The reference model treats each accepted byte as a queue of tape samples.
// Each bit contributes half ones followed by half zeros.
// On every rising edge with the motor on, the model pops one sample, which
// becomes the expected tape_out. With the motor off, tape_out is expected
// to be 0 and nothing advances.
module tb_cassette_fsk_tx;

    localparam int HALF0 = 4;
    localparam int HALF1 = 2;

    logic       clk;
    logic       reset;
    logic       motor_on;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tape_out;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic exp_q[$];
    logic m_out = 1'b0;
    logic m_busy = 1'b0;
    logic seen_reset = 1'b0;
    int   n_acc = 0;
    int   cyc = 0;
    int   acc_prev = 0;
    int   acc_last = 0;

    cassette_fsk_tx #(
        .HALF0(HALF0),
        .HALF1(HALF1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .motor_on(motor_on),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tape_out(tape_out),
        .busy    (busy)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model update on every rising edge, then compare registered outputs
    always @(posedge clk) begin
        logic [7:0] b;
        int         h;
        cyc++;
        if (reset) begin
            exp_q.delete();
            m_busy     = 1'b0;
            m_out      = 1'b0;
            seen_reset = 1'b1;
        end else if (motor_on) begin
            if (exp_q.size() == 0) begin
                if (in_valid) begin
                    b = in_data;
                    for (int i = 0; i < 8; i++) begin
                        h = b[i] ? HALF1 : HALF0;
                        for (int k = 0; k < h; k++) exp_q.push_back(1'b1);
                        for (int k = 0; k < h; k++) exp_q.push_back(1'b0);
                    end
                    m_busy   = 1'b1;
                    n_acc++;
                    acc_prev = acc_last;
                    acc_last = cyc;
                end else begin
                    m_busy = 1'b0;
                end
            end
            m_out = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
        end else begin
            m_out = 1'b0;
        end
        #1;
        if (seen_reset) begin
            check("tape_out", tape_out, m_out);
            check("busy", busy, m_busy);
        end
    end

    // in_ready is combinational from the current inputs, so check it after they settle
    always @(negedge clk) begin
        #1;
        if (seen_reset)
            check("in_ready", in_ready, motor_on && !reset && (exp_q.size() == 0));
    end

    task automatic send_byte(input logic [7:0] b, input bit keep_valid);
        int start;
        int guard;
        start    = n_acc;
        guard    = 0;
        in_data  = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (n_acc == start && guard < 500);
        check("accept_seen", n_acc != start, 1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard    = 0;
        motor_on = 1'b1;
        while ((busy !== 1'b0 || exp_q.size() != 0) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("idle_reached", guard < 1000, 1);
        @(negedge clk);
    endtask

    // Counts busy cycles and tape_out ones from the current cycle until idle.
    // Motor is dropped for cycles [p_start, p_start+p_len).
    task automatic measure(input int p_start, input int p_len, output int nbusy, output int nones);
        int i;
        nbusy = 0;
        nones = 0;
        i     = 0;
        while (busy === 1'b1 && i < 400) begin
            nbusy++;
            if (tape_out === 1'b1) nones++;
            i++;
            motor_on = !(i >= p_start && i < p_start + p_len);
            @(negedge clk);
        end
        motor_on = 1'b1;
    endtask

    task automatic rand_stream(input int nbytes);
        int gap;
        int start;
        int guard;
        for (int n = 0; n < nbytes; n++) begin
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                in_valid = 1'b0;
                repeat (gap) begin
                    motor_on = ($urandom_range(0, 9) != 0);
                    @(negedge clk);
                end
            end
            in_data  = 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            start    = n_acc;
            guard    = 0;
            while (n_acc == start && guard < 2000) begin
                motor_on = ($urandom_range(0, 9) != 0);
                @(negedge clk);
                guard++;
            end
            check("rand_accept", n_acc != start, 1);
        end
        in_valid = 1'b0;
        motor_on = 1'b1;
    endtask

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Stimulus
    initial begin
        int nb;
        int no;
        int a0;
        reset    = 1'b1;
        motor_on = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;

        // Reset with in_valid held high: nothing may be accepted
        repeat (3) begin
            @(negedge clk);
            check("rst_tape", tape_out, 0);
            check("rst_busy", busy, 0);
            check("rst_ready", in_ready, 0);
        end
        check("rst_no_accept", n_acc, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_ready", in_ready, 1);

        // Single byte 0x01: 4 + 7*8 = 60 busy cycles, 2 + 7*4 = 30 high cycles
        send_byte(8'h01, 1'b0);
        measure(1000, 0, nb, no);
        check("b01_busy_len", nb, 60);
        check("b01_ones", no, 30);
        wait_idle();

        // Back-to-back 0xFF then 0x00: second accept exactly 32 cycles later
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b0);
        check("b2b_gap", acc_last - acc_prev, 32);
        wait_idle();

        // Motor pause of 10 cycles in the HIGH phase of bit 2 of 0xAA
        send_byte(8'hAA, 1'b0);
        measure(13, 10, nb, no);
        check("pause_busy_len", nb, 58);
        check("pause_ones", no, 24);
        wait_idle();

        // Reset during bit 4 of 0x55, then 0x0F plays in full
        send_byte(8'h55, 1'b0);
        repeat (25) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_tape", tape_out, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        send_byte(8'h0F, 1'b0);
        a0 = n_acc;
        measure(1000, 0, nb, no);
        check("b0f_busy_len", nb, 48);
        check("b0f_ones", no, 24);
        wait_idle();

        // Handshake stall while motor is off
        motor_on = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        a0       = n_acc;
        repeat (8) begin
            @(negedge clk);
            check("stall_ready", in_ready, 0);
        end
        check("stall_no_accept", n_acc, a0);
        motor_on = 1'b1;
        @(negedge clk);
        check("stall_release", n_acc, a0 + 1);
        in_valid = 1'b0;
        wait_idle();

        // Randomized stream with random motor drops and idle gaps
        rand_stream(40);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
